window_builder: RTL

WINDOW_BUILDER -- requirements
Module: window_builder

---
 rtl/lsh_pkg.sv | 21 ++
 rtl/window_builder_if.sv | 21 ++
 rtl/window_builder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/lsh_pkg.sv
// Shared types and defaults for the LSH front end: nucleotide code,
// window builder FSM states and size defaults.
package lsh_pkg;

  localparam int unsigned WINDOW_SIZE_DEF = 128;
  localparam int unsigned KMER_SIZE_DEF   = 16;

  typedef enum logic [1:0] {
    BASE_A = 2'd0,
    BASE_C = 2'd1,
    BASE_G = 2'd2,
    BASE_T = 2'd3
  } base_t;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_PRESENT,
    ST_CLEAR
  } wb_state_t;

endpackage

// File: rtl/window_builder_if.sv
// Base stream handshake into the window builder.
// With WINDOW_BUILDER_AMBIG_EN defined the stream also carries base_ambig.
interface window_builder_if;

  logic       base_valid;
  logic [1:0] base;
  logic       seq_end;
  logic       base_ready;
`ifdef WINDOW_BUILDER_AMBIG_EN
  logic       base_ambig;
`endif

`ifdef WINDOW_BUILDER_AMBIG_EN
  modport master (output base_valid, base, seq_end, base_ambig, input base_ready);
  modport slave  (input base_valid, base, seq_end, base_ambig, output base_ready);
`else
  modport master (output base_valid, base, seq_end, input base_ready);
  modport slave  (input base_valid, base, seq_end, output base_ready);
`endif

endinterface

// File: rtl/window_builder.sv
// Collects bases into overlapping windows and hands each one to the hasher.
// Optional ambiguous-base poisoning is enabled by WINDOW_BUILDER_AMBIG_EN.
module window_builder
  import lsh_pkg::*;
#(
  parameter int unsigned WINDOW_SIZE = WINDOW_SIZE_DEF,
  parameter int unsigned STRIDE      = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  window_builder_if.slave                 s,
  output logic [0:WINDOW_SIZE-1][1:0]     window,
  output logic                            ready_for_hashing,
  input  logic                            hashing_is_done,
  output logic                            hasher_reset,
  output logic [CNT_W-1:0]                window_count,
  output logic                            partial_drop
);

  localparam int unsigned CW = $clog2(WINDOW_SIZE + 1);
  localparam logic [CW-1:0] NEED_WIN = CW'(WINDOW_SIZE);
  localparam logic [CW-1:0] NEED_STR = CW'(STRIDE);

  wb_state_t                       state_q;
  base_t [0:WINDOW_SIZE-1]         window_q;
  logic [CW-1:0]                   cnt_q;
  logic                            need_full_q;
  logic                            last_end_q;
  logic                            base_ready_q;
  logic                            rfh_q;
  logic                            hasher_reset_q;
  logic                            partial_drop_q;
  logic [CNT_W-1:0]                wcount_q;

  logic [CW-1:0]                   need;
  logic [CW-1:0]                   cnt_inc;
  logic                            accept;
  logic                            complete;
  logic                            poisoned;

`ifdef WINDOW_BUILDER_AMBIG_EN
  logic [CW-1:0]                   poison_q;
  logic [CW-1:0]                   poison_d;
`endif

  always_comb begin
    need     = need_full_q ? NEED_WIN : NEED_STR;
    cnt_inc  = cnt_q + CW'(1);
    accept   = s.base_valid && base_ready_q;
    complete = (cnt_inc == need);
    poisoned = 1'b0;
`ifdef WINDOW_BUILDER_AMBIG_EN
    // Counter value after this base: nonzero while an ambiguous base is still inside the window.
    if (s.base_ambig)          poison_d = NEED_WIN;
    else if (poison_q != '0)   poison_d = poison_q - CW'(1);
    else                       poison_d = poison_q;
    poisoned = (poison_d != '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_FILL;
      window_q       <= '0;
      cnt_q          <= '0;
      need_full_q    <= 1'b1;
      last_end_q     <= 1'b0;
      base_ready_q   <= 1'b1;
      rfh_q          <= 1'b0;
      hasher_reset_q <= 1'b0;
      partial_drop_q <= 1'b0;
      wcount_q       <= '0;
`ifdef WINDOW_BUILDER_AMBIG_EN
      poison_q       <= '0;
`endif
    end else begin
      hasher_reset_q <= 1'b0;
      partial_drop_q <= 1'b0;
      unique case (state_q)
        ST_FILL: begin
          if (accept) begin
            for (int unsigned i = 0; i < WINDOW_SIZE - 1; i++) begin
              window_q[i] <= window_q[i+1];
            end
            window_q[WINDOW_SIZE-1] <= base_t'(s.base);
`ifdef WINDOW_BUILDER_AMBIG_EN
            poison_q <= poison_d;
`endif
            if (complete) begin
              cnt_q <= '0;
              if (poisoned) begin
                need_full_q <= s.seq_end;
              end else begin
                state_q      <= ST_PRESENT;
                last_end_q   <= s.seq_end;
                base_ready_q <= 1'b0;
                rfh_q        <= 1'b1;
              end
            end else if (s.seq_end) begin
              partial_drop_q <= 1'b1;
              cnt_q          <= '0;
              need_full_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        ST_PRESENT: begin
          if (hashing_is_done) begin
            state_q        <= ST_CLEAR;
            rfh_q          <= 1'b0;
            hasher_reset_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // Count is committed on leaving CLEAR so a reset in PRESENT never bumps it.
          state_q      <= ST_FILL;
          base_ready_q <= 1'b1;
          wcount_q     <= wcount_q + CNT_W'(1);
          need_full_q  <= last_end_q;
          cnt_q        <= '0;
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  assign s.base_ready        = base_ready_q;
  assign window              = window_q;
  assign ready_for_hashing   = rfh_q;
  assign hasher_reset        = hasher_reset_q;
  assign window_count        = wcount_q;
  assign partial_drop        = partial_drop_q;

endmodule
